// File: rtl/mmio_arb.sv
// mmio_arb: round-robin arbiter/sequencer for the shared mmio register port.
// Each transaction is latched on grant, issued as one io_en cycle, then answered.
// Optional feature macro: MMIO_ARB_ADDR_CHECK_EN (address range / alignment check;
// bad requests skip the mmio access and answer with rsp_err=1).
module mmio_arb #(
    parameter int          NREQ     = 2,
    parameter logic [31:0] IO_START = 32'h0000_1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*32-1:0]   req_addr,
    input  logic [NREQ*32-1:0]   req_wdata,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*2-1:0]    req_dw,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 io_en,
    output logic [31:0]          addr,
    output logic [31:0]          wdata,
    output logic                 mem_rw,
    output logic [1:0]           dw,
    input  logic [31:0]          io_read
);

    // Access widths: DB=0 (byte), DH=1 (half), DW=2 (word).
    localparam logic [1:0] DW_WORD = 2'd2;
`ifdef MMIO_ARB_ADDR_CHECK_EN
    localparam logic [1:0] DW_HALF = 2'd1;
`endif
    localparam int PW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_rr_ptr;
    logic [PW-1:0]   r_gsel;
    logic            r_we;
    logic            r_err;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [1:0]      r_dw;

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic              w_found;
    logic [PW-1:0]     w_win;
    logic [PW-1:0]     w_rr_nxt;
    logic [31:0]       w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic              w_sel_we;
    logic [1:0]        w_sel_dw;
    logic              w_err;

    // Round-robin pick: rotate requests so rr_ptr sits at bit 0, take the first set bit.
    always_comb begin
        int w_idx;
        w_dbl   = {req, req} >> r_rr_ptr;
        w_rot   = w_dbl[NREQ-1:0];
        w_found = 1'b0;
        w_idx   = 0;
        for (int j = 0; j < NREQ; j++) begin
            if (!w_found && w_rot[j]) begin
                w_found = 1'b1;
                w_idx   = int'(r_rr_ptr) + j;
                if (w_idx >= NREQ) w_idx = w_idx - NREQ;
            end
        end
        w_win    = PW'(w_idx);
        w_rr_nxt = (w_idx == NREQ - 1) ? '0 : PW'(w_idx + 1);
    end

    // Mux the winning requester's fields and evaluate the optional address check.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        w_sel_dw    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == PW'(i)) begin
                w_sel_addr  = req_addr[i*32 +: 32];
                w_sel_wdata = req_wdata[i*32 +: 32];
                w_sel_we    = req_we[i];
                w_sel_dw    = req_dw[i*2 +: 2];
            end
        end
`ifdef MMIO_ARB_ADDR_CHECK_EN
        w_err = (w_sel_addr < IO_START) ||
                ((w_sel_dw == DW_HALF) && w_sel_addr[0]) ||
                ((w_sel_dw == DW_WORD) && (w_sel_addr[1:0] != 2'b00));
`else
        w_err = 1'b0;
`endif
    end

    // State, round-robin pointer and the latched transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_gsel   <= '0;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_dw     <= DW_WORD;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_found) begin
                r_rr_ptr <= w_rr_nxt;
                r_gsel   <= w_win;
                r_we     <= w_sel_we;
                r_err    <= w_err;
                r_addr   <= w_sel_addr;
                r_wdata  <= w_sel_wdata;
                r_dw     <= w_sel_dw;
            end
        end
    end

    // Next state and per-cycle strobes; grant/response are suppressed while in reset.
    always_comb begin
        w_state_nxt = r_state;
        gnt         = '0;
        rsp_valid   = '0;
        rsp_rdata   = '0;
        rsp_err     = 1'b0;
        io_en       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = w_err ? S_RESP : S_ISSUE;
                    if (!rst) begin
                        for (int i = 0; i < NREQ; i++) gnt[i] = (w_win == PW'(i));
                    end
                end
            end
            S_ISSUE: begin
                io_en       = 1'b1;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
                if (!rst) begin
                    for (int i = 0; i < NREQ; i++) rsp_valid[i] = (r_gsel == PW'(i));
                    rsp_rdata = (r_we || r_err) ? 32'h0 : io_read;
                    rsp_err   = r_err;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign addr   = r_addr;
    assign wdata  = r_wdata;
    assign mem_rw = r_we;
    assign dw     = r_dw;

endmodule

// File: tb/tb_mmio_arb.sv
// tb_mmio_arb: directed scenarios plus randomized traffic, checked every cycle
// against a transaction-timeline model of the arbiter.
module tb_mmio_arb;

    localparam int          NREQ = 2;
    localparam logic [31:0] IOS  = 32'h0000_1000;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*32-1:0]   req_addr = '0;
    logic [NREQ*32-1:0]   req_wdata = '0;
    logic [NREQ-1:0]      req_we = '0;
    logic [NREQ*2-1:0]    req_dw = '0;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rsp_valid;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;
    logic                 io_en;
    logic [31:0]          addr;
    logic [31:0]          wdata;
    logic                 mem_rw;
    logic [1:0]           dw;
    logic [31:0]          io_read = '0;

    int checks = 0;
    int errors = 0;

    mmio_arb #(.NREQ(NREQ), .IO_START(IOS)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_we(req_we), .req_dw(req_dw), .gnt(gnt), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .io_en(io_en), .addr(addr),
        .wdata(wdata), .mem_rw(mem_rw), .dw(dw), .io_read(io_read)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic addr_bad(input logic [31:0] a, input logic [1:0] d);
        logic bad;
        bad = (a < IOS) || (d == 2'd1 && a[0]) || (d == 2'd2 && a[1:0] != 2'b00);
`ifdef MMIO_ARB_ADDR_CHECK_EN
        return bad;
`else
        return 1'b0 & bad;
`endif
    endfunction

    // Model: each accepted transaction occupies a known cycle window
    // (grant at c, access at c+1, answer at c+2; or answer at c+1 when rejected).
    int              cyc = 0;
    int              m_issue = -1;
    int              m_resp = -1;
    int              m_g = 0;
    int              m_rr = 0;
    logic            m_we = 1'b0;
    logic            m_err = 1'b0;
    logic [31:0]     m_addr = '0;
    logic [31:0]     m_wdata = '0;
    logic [1:0]      m_dw = 2'd2;
    logic [NREQ-1:0] m_last_gnt = '0;

    always @(negedge clk) begin : model
        int w;
        logic idle;
        logic [NREQ-1:0] eg;
        logic [NREQ-1:0] ev;
        logic [31:0] erd;
        logic ee;
        idle = (cyc > m_resp);
        w = -1;
        if (idle && !rst) begin
            for (int j = 0; j < NREQ; j++) begin
                int k;
                k = (m_rr + j) % NREQ;
                if (w < 0 && req[k]) w = k;
            end
        end
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        ev = '0; erd = '0; ee = 1'b0;
        if (cyc == m_resp && !rst) begin
            ev[m_g] = 1'b1;
            ee = m_err;
            erd = (m_we || m_err) ? 32'h0 : io_read;
        end
        chk("gnt", 32'(gnt), 32'(eg));
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        chk("rsp_rdata", rsp_rdata, erd);
        chk("rsp_err", 32'(rsp_err), 32'(ee));
        chk("io_en", 32'(io_en), 32'(cyc == m_issue));
        chk("addr", addr, m_addr);
        chk("wdata", wdata, m_wdata);
        chk("mem_rw", 32'(mem_rw), 32'(m_we));
        chk("dw", 32'(dw), 32'(m_dw));
        m_last_gnt = eg;
        if (rst) begin
            m_resp = cyc; m_issue = -1; m_rr = 0;
            m_addr = '0; m_wdata = '0; m_we = 1'b0; m_err = 1'b0; m_dw = 2'd2;
        end else if (w >= 0) begin
            m_g     = w;
            m_rr    = (w + 1) % NREQ;
            m_addr  = req_addr[w*32 +: 32];
            m_wdata = req_wdata[w*32 +: 32];
            m_we    = req_we[w];
            m_dw    = req_dw[w*2 +: 2];
            m_err   = addr_bad(m_addr, m_dw);
            if (m_err) begin m_issue = -1; m_resp = cyc + 1; end
            else begin m_issue = cyc + 1; m_resp = cyc + 2; end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk); #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d,
                           input logic we, input logic [1:0] w);
        req_addr[i*32 +: 32] = a;
        req_wdata[i*32 +: 32] = d;
        req_we[i] = we;
        req_dw[i*2 +: 2] = w;
        req[i] = 1'b1;
    endtask

    initial begin
        int cnt_g1, cnt_io;
        rst = 1'b1;
        step(); smp();
        chk("rst_io_en", 32'(io_en), 32'h0);
        chk("rst_dw", 32'(dw), 32'h2);
        step(); rst = 1'b0;

        // Read on port 0
        set_req(0, IOS + 32'd4, 32'h0, 1'b0, 2'd2); io_read = 32'hDEADBEEF;
        smp(); chk("rd_gnt", 32'(gnt), 32'h1);
        step(); req[0] = 1'b0;
        smp(); chk("rd_io_en", 32'(io_en), 32'h1); chk("rd_rw", 32'(mem_rw), 32'h0);
        chk("rd_addr", addr, IOS + 32'd4);
        step();
        smp(); chk("rd_vld", 32'(rsp_valid), 32'h1); chk("rd_data", rsp_rdata, 32'hDEADBEEF);
        step();

        // Byte write on port 1
        set_req(1, IOS + IOS / 2, 32'hA5, 1'b1, 2'd0);
        smp(); chk("wr_gnt", 32'(gnt), 32'h2);
        step(); req[1] = 1'b0;
        smp(); chk("wr_io_en", 32'(io_en), 32'h1); chk("wr_rw", 32'(mem_rw), 32'h1);
        chk("wr_dw", 32'(dw), 32'h0); chk("wr_wdata", wdata, 32'hA5);
        step();
        smp(); chk("wr_vld", 32'(rsp_valid), 32'h2); chk("wr_data", rsp_rdata, 32'h0);
        step();

        // Contention from reset: grants alternate every 3 cycles
        rst = 1'b1;
        set_req(0, IOS + 32'h10, 32'h0, 1'b0, 2'd2);
        set_req(1, IOS + 32'h20, 32'h0, 1'b0, 2'd2);
        step(); rst = 1'b0;
        for (int n = 0; n < 12; n++) begin
            io_read = $urandom;
            smp();
            if (n % 3 == 0) chk("rr_gnt", 32'(gnt), ((n / 3) % 2 == 0) ? 32'h1 : 32'h2);
            if (n % 3 == 2) chk("rr_vld", 32'(rsp_valid), ((n / 3) % 2 == 0) ? 32'h1 : 32'h2);
            step();
        end
        req = '0;
        step(); step();

        // Reset during the access cycle abandons the transaction
        set_req(0, IOS + 32'h40, 32'h0, 1'b0, 2'd2);
        smp(); chk("rs_gnt", 32'(gnt), 32'h1);
        step(); req[0] = 1'b0; rst = 1'b1;
        smp();
        step(); rst = 1'b0;
        smp(); chk("rs_io_en", 32'(io_en), 32'h0); chk("rs_vld", 32'(rsp_valid), 32'h0);
        step();
        set_req(1, IOS + 32'h44, 32'h0, 1'b0, 2'd2);
        smp(); chk("rs_gnt1", 32'(gnt), 32'h2);
        step(); req[1] = 1'b0;
        step(); step();

        // Misaligned word read
        set_req(0, IOS + 32'd2, 32'h0, 1'b0, 2'd2);
        smp(); chk("ac_gnt", 32'(gnt), 32'h1);
        step(); req[0] = 1'b0;
        smp();
`ifdef MMIO_ARB_ADDR_CHECK_EN
        chk("ac_io_en", 32'(io_en), 32'h0); chk("ac_vld", 32'(rsp_valid), 32'h1);
        chk("ac_err", 32'(rsp_err), 32'h1); chk("ac_data", rsp_rdata, 32'h0);
`else
        chk("ac_io_en", 32'(io_en), 32'h1); chk("ac_vld", 32'(rsp_valid), 32'h0);
`endif
        step(); step(); step();

        // Withdrawn request: port 1 pulses req only while the FSM is busy
        set_req(0, IOS + 32'h80, 32'h0, 1'b0, 2'd2);
        smp(); chk("wd_gnt0", 32'(gnt), 32'h1);
        step(); req[0] = 1'b0; set_req(1, IOS + 32'h84, 32'h0, 1'b0, 2'd2);
        smp(); chk("wd_io_en", 32'(io_en), 32'h1);
        step(); req[1] = 1'b0;
        cnt_g1 = 0; cnt_io = 0;
        for (int n = 0; n < 6; n++) begin
            smp();
            if (gnt[1]) cnt_g1++;
            if (io_en) cnt_io++;
            step();
        end
        chk("wd_gnt1_cnt", 32'(cnt_g1), 32'h0);
        chk("wd_io_cnt", 32'(cnt_io), 32'h0);

        // Randomized traffic with withdrawals, re-requests and occasional reset
        for (int t = 0; t < 3000; t++) begin
            rst = ($urandom_range(0, 199) == 0);
            io_read = $urandom;
            for (int i = 0; i < NREQ; i++) begin
                if (m_last_gnt[i]) req[i] = 1'b0;
                if (req[i] && $urandom_range(0, 19) == 0) req[i] = 1'b0;
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    logic [31:0] a;
                    if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, 32'(IOS) - 1));
                    else a = IOS + 32'($urandom_range(0, 255));
                    set_req(i, a, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)));
                end
            end
            step();
        end
        rst = 1'b0; req = '0;
        step(); step(); step(); step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
